mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit serving MULT, MULTU, DIV and DIVU, with HI/LO result registers.
- Acts as responder: the datapath issues a start request with operands and waits on busy/done.
- Sits beside the single-cycle ALU and provides MFHI/MFLO read data and MTHI/MTLO write support.
- The radix-2 engine runs a fixed 32 iterations, then pulses done.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles. Fixed equal to WIDTH and not user-overridable in practice.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand/dividend).
- b  in  WIDTH  rt operand (multiplier/divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while iterating.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  valid with done; high if a DIV/DIVU had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, internal counters/shift registers=0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN counts 32 iterations, one per clk.
  - RUN -> FIN after the 32nd iteration edge.
  - FIN lasts one cycle, then returns to IDLE, or goes straight to RUN if start is high in that cycle.
- Latency: start sampled at edge E0.
  - busy=1 for the cycles following E0 through E32.
  - At E32, hi/lo are written and done=1 for one cycle; busy=0 in that cycle.
  - Back-to-back start during the done cycle is accepted.
- Operands and op are latched at E0; later changes on a/b/op have no effect.
- start while busy=1 is ignored; no queueing.
- Multiply: {hi,lo} = full 2*WIDTH product.
  - MULT is signed: magnitudes are multiplied, then the product is negated if operand signs differ.
  - MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Restoring, one quotient bit per cycle on magnitudes.
  - Quotient is negated if signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0. No trap.
  - b=0: still 32-cycle latency; lo=all ones, hi=a, div_by_zero=1 with done.
- div_by_zero is 0 for multiplies. It holds its value until the next done.
- MTHI/MTLO:
  - When busy=0 and start=0, hi_we/lo_we write wdata into hi/lo at the clock edge. Both may write in the same cycle.
  - Writes are ignored while busy=1.
  - If start and a write enable are high together, start wins and the write is dropped.
- hi/lo hold their previous values throughout RUN and update only at E32, so MFHI during busy reads the old value.
- Reset asserted mid-operation: immediately clears busy/done/hi/lo with no clock needed. A new start is accepted on the first edge after reset deasserts.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 while busy=1 returns the unit to IDLE at the next edge: busy=0, no done pulse, hi/lo/div_by_zero unchanged.
  - cancel in IDLE or FIN has no effect.
  - cancel and start in the same IDLE cycle: start is accepted and cancel is ignored.
- Undefined: no cancel port; every accepted start runs to completion unless reset.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 32 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=25, b=0xFFFFFFF1 (-15) -> lo=0xFFFFFFFF, hi=0x0000000A, div_by_zero=0. Then DIVU same operands -> lo=0, hi=25.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Handshake/writes:
  - Second start at cycle 5 of a run is ignored; result matches the first operands.
  - hi_we with wdata=0x1234 during busy leaves hi unchanged.
  - lo_we=1 with wdata=0xABCD in IDLE -> lo=0xABCD next cycle.
  - Start issued in the done cycle -> new run begins with no idle gap.
- Reset at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately. With MDU_CANCEL_EN, cancel at cycle 10 -> busy=0 next edge, no done, hi/lo retain prior values.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: datapath-to-MDU request/result bundle; carries cancel only when MDU_CANCEL_EN is defined.
`timescale 1ns/1ps
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_CANCEL_EN
  logic             cancel;
  modport master(output start, op, a, b, hi_we, lo_we, wdata, cancel,
                 input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata, cancel,
                output busy, done, div_by_zero, hi, lo);
`else
  modport master(output start, op, a, b, hi_we, lo_we, wdata,
                 input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata,
                output busy, done, div_by_zero, hi, lo);
`endif
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, 32 iterations per op.
// Optional MDU_CANCEL_EN adds a cancel input that aborts a running operation.
`timescale 1ns/1ps
module mdu_iter #(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int ITER = WIDTH;
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t             r_state;
  logic               r_busy, r_done, r_dz, r_neg_q, r_neg_r;
  logic [1:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_m;
  logic [2*WIDTH-1:0] r_p;
  logic               w_sgn, w_go, w_cancel, w_dz;
  logic [WIDTH-1:0]   w_am, w_bm, w_q, w_r, w_res_hi, w_res_lo;
  logic [WIDTH:0]     w_sum, w_sh, w_diff;
  logic [2*WIDTH-1:0] w_mul_p, w_div_p, w_next_p, w_prod;
  assign w_sgn = ~bus.op[0];
  assign w_am  = (w_sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_bm  = (w_sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_go  = bus.start & (r_state != RUN);
`ifdef MDU_CANCEL_EN
  assign w_cancel = bus.cancel;
`else
  assign w_cancel = 1'b0;
`endif
  // Multiply: add-and-shift-right over {acc, multiplier}.
  assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_p = {w_sum, r_p[WIDTH-1:1]};
  // Divide: restoring step over {remainder, dividend/quotient}.
  assign w_sh    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff  = w_sh - {1'b0, r_m};
  assign w_div_p = {w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0], r_p[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_next_p = r_op[1] ? w_div_p : w_mul_p;
  assign w_prod   = r_neg_q ? -w_next_p : w_next_p;
  assign w_q      = w_next_p[WIDTH-1:0];
  assign w_r      = w_next_p[2*WIDTH-1:WIDTH];
  assign w_dz     = r_op[1] & (r_m == '0);
  assign w_res_hi = !r_op[1] ? w_prod[2*WIDTH-1:WIDTH] : w_dz ? r_a : r_neg_r ? -w_r : w_r;
  assign w_res_lo = !r_op[1] ? w_prod[WIDTH-1:0] : w_dz ? '1 : r_neg_q ? -w_q : w_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_m     <= '0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_go) begin
        r_state <= RUN;
        r_busy  <= 1'b1;
        r_op    <= bus.op;
        r_a     <= bus.a;
        r_m     <= bus.op[1] ? w_bm : w_am;
        r_p     <= {{WIDTH{1'b0}}, bus.op[1] ? w_am : w_bm};
        r_neg_q <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_neg_r <= w_sgn & bus.a[WIDTH-1];
        r_cnt   <= '0;
      end else if (r_state == RUN && w_cancel) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (r_state == RUN) begin
        r_p   <= w_next_p;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(ITER - 1)) begin
          r_state <= FIN;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dz    <= w_dz;
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
        end
      end else begin
        r_state <= IDLE;
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter latency, arithmetic, HI/LO writes, reset and cancel.
`timescale 1ns/1ps
module tb_mdu_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  mdu_if #(.WIDTH(32)) bus();
  mdu_iter #(.WIDTH(32)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
  endtask
  task automatic wait_res(input string tag, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int cyc = 1;
    int nb = int'(bus.busy);
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) nb++;
    end
    chk({tag, "_lat"}, cyc, 33);
    chk({tag, "_busycyc"}, nb, 32);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
    chk({tag, "_dz"}, bus.div_by_zero, edz);
  endtask
  task automatic finish_start();
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    @(negedge clk);
    drive_start(op, a, b);
    finish_start();
    wait_res(tag, ehi, elo, edz);
  endtask
  initial begin
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
`ifdef MDU_CANCEL_EN
    bus.cancel = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b0;
    run("mult", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    run("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("div", 2'b10, 32'd25, 32'hFFFF_FFF1, 32'h0000_000A, 32'hFFFF_FFFF, 1'b0);
    run("divu", 2'b11, 32'd25, 32'hFFFF_FFF1, 32'd25, 32'd0, 1'b0);
    run("divu0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("dz_hold", bus.div_by_zero, 1);
    run("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    // Second start and an MTHI mid-run must both be ignored; operand changes too.
    @(negedge clk);
    drive_start(2'b01, 32'd6, 32'd7);
    finish_start();
    bus.a = 32'd100;
    bus.b = 32'd3;
    bus.op = 2'b11;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("mthi_busy_hi", bus.hi, 0);
    chk("mflo_busy_old", bus.lo, 32'h8000_0000);
    chk("restart_busy", bus.busy, 1);
    repeat (27) @(negedge clk);
    chk("ign_done", bus.done, 1);
    chk("ign_hi", bus.hi, 0);
    chk("ign_lo", bus.lo, 32'd42);
    @(negedge clk);
    chk("ign_idle", bus.busy, 0);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hABCD);
    chk("mtlo_hi", bus.hi, 0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5555;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("both_hi", bus.hi, 32'h5555);
    chk("both_lo", bus.lo, 32'h5555);
    drive_start(2'b00, 32'd2, 32'd3);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hFFFF;
    finish_start();
    chk("start_wins_lo", bus.lo, 32'h5555);
    wait_res("b2b_first", 32'd0, 32'd6, 1'b0);
    drive_start(2'b01, 32'd5, 32'd5);
    finish_start();
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    wait_res("b2b_second", 32'd0, 32'd25, 1'b0);
    @(negedge clk);
    drive_start(2'b00, 32'hFFFF_FFFD, 32'd7);
    finish_start();
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
`ifdef MDU_CANCEL_EN
    begin
      int seen = 0;
      @(negedge clk);
      drive_start(2'b00, 32'hFFFF_FFFD, 32'd7);
      finish_start();
      repeat (9) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      chk("cancel_busy", bus.busy, 0);
      chk("cancel_hi", bus.hi, 0);
      chk("cancel_lo", bus.lo, 32'd12);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen++;
      end
      chk("cancel_nodone", seen, 0);
      chk("cancel_lo_kept", bus.lo, 32'd12);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
